// File: rtl/limber_uart_tx_fifo_rd.sv
// ---------------------------------------------------------------------------
// limber_uart_tx_fifo_rd
//
// UART transmitter that drains the read port of a limber_gnrl_fifo_syn.
// One FIFO word is popped per frame and sent on txd as: start bit, DW data
// bits LSB first, an optional parity bit, and one stop bit. A new word may be
// popped in the last cycle of the stop bit, so queued frames go out with no
// idle gap between them.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   baud_div    clocks per bit minus 1, latched at each pop
//   tx_en       permit new frames; a frame in flight always completes
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data at the current read pointer
//   fifo_ren    FIFO pop strobe, one cycle per word
//   txd         registered serial output, idle high
//   busy        frame in progress
//   frame_done  one-cycle pulse in the last cycle of the stop bit
// ---------------------------------------------------------------------------
module limber_uart_tx_fifo_rd #(
    parameter int unsigned DW         = 8,
    parameter int unsigned DIV_W      = 16,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_dout,
    output logic             fifo_ren,
    output logic             txd,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned   BW      = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BW-1:0] LastBit = BW'(DW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;

    logic bit_end;
    logic last_bit;
    logic pop;

    assign bit_end  = (baud_cnt_q == div_q);
    assign last_bit = (bit_cnt_q == LastBit);

    // Gated by rst so a reset cycle can never consume a FIFO word.
    assign pop = ~rst & tx_en & ~fifo_empty &
                 ((state_q == StIdle) | ((state_q == StStop) & bit_end));

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && last_bit) begin
                    state_d = PARITY_EN ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = pop ? StStart : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM outputs
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_ren   = pop;
        busy       = (state_q != StIdle);
        frame_done = (state_q == StStop) & bit_end;
        txd        = txd_q;
    end

    // -----------------------------------------------------------------------
    // Datapath next-state
    // -----------------------------------------------------------------------
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;

        if (pop || (state_q == StIdle) || bit_end) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + DIV_W'(1);
        end

        if (pop) begin
            div_d     = baud_div;
            shift_d   = fifo_dout;
            bit_cnt_d = '0;
            par_d     = 1'b0;
        end else if ((state_q == StData) && bit_end) begin
            shift_d   = shift_q >> 1;
            par_d     = par_q ^ shift_q[0];
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
        end

        // txd is registered from the upcoming state so it lines up with state_q.
        unique case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
            StParity: txd_d = par_d ^ PARITY_ODD;
            default:  txd_d = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
        end
    end

endmodule
